conv3x3_stream_engine: RTL and testbench

Parametrised 3x3 streaming convolution engine for the convolution datapath. It accepts a raster-order pixel stream of run-time size (cols x rows), buffers two image lines internally, and applies zero padding at all four borders. It performs a full-precision signed 3x3 multiply-accumulate with a loadable kernel and emits one result per input pixel, in raster order, over a valid/ready stream. It supersedes the fixed buffer/padding pair with configurable width, depth, precision and backpressure.

---
 rtl/conv3x3_stream_engine.sv | 213 +++++++++++++++++++++
 tb/tb_conv3x3_stream_engine.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/conv3x3_stream_engine.sv
// conv3x3_stream_engine: raster-order 3x3 convolution with zero padding.
// Two line buffers feed a 3x3 window; a signed full-precision MAC on the
// window being formed is registered into a valid/ready output stage.
// Build option: define CONV_RELU_EN to clamp negative results to zero.
module conv3x3_stream_engine #(
  parameter int DATA_W   = 8,
  parameter int COEF_W   = 8,
  parameter int MAX_COLS = 16,
  parameter int ROW_W    = 8,
  parameter int ACC_W    = DATA_W + COEF_W + 5
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic [$clog2(MAX_COLS+1)-1:0]   cfg_cols,
  input  logic [ROW_W-1:0]                cfg_rows,
  input  logic                            coef_we,
  input  logic [3:0]                      coef_addr,
  input  logic [COEF_W-1:0]               coef_data,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [DATA_W-1:0]               in_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [ACC_W-1:0]                out_data,
  output logic                            out_last,
  output logic                            busy,
  output logic                            done,
  output logic                            err
);
  localparam int COL_W = $clog2(MAX_COLS + 1);
  localparam int PTR_W = (MAX_COLS > 1) ? $clog2(MAX_COLS) : 1;
  localparam int KW    = ROW_W + COL_W + 1;
  localparam logic [KW-1:0]    KW_ONE  = 1;
  localparam logic [PTR_W-1:0] PTR_ONE = 1;
  localparam logic [ROW_W-1:0] ROW_ONE = 1;
  localparam logic [COL_W-1:0] COL_ONE = 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_STREAM = 2'd1;
  localparam logic [1:0] S_DRAIN  = 2'd2;

  logic [1:0]        state_q;
  logic [COL_W-1:0]  cols_q;
  logic [ROW_W-1:0]  rows_q;
  logic [KW-1:0]     total_q, k_q;
  logic [PTR_W-1:0]  ptr_q, cc_q;
  logic [ROW_W-1:0]  cr_q;
  logic              out_valid_q, out_last_q, done_q, err_q;
  logic [ACC_W-1:0]  out_data_q;
  logic [COEF_W-1:0] coef_q [9];
  logic [DATA_W-1:0] win_q  [9];
  logic [DATA_W-1:0] win_d  [9];
  logic [DATA_W-1:0] lb_top_mem [MAX_COLS];
  logic [DATA_W-1:0] lb_mid_mem [MAX_COLS];

  logic              stall, step, produce, is_last, cfg_ok;
  logic [KW-1:0]     steps_end;
  logic [DATA_W-1:0] pix_in;
  logic [2:0]        row_ok, col_ok;
  logic signed [ACC_W-1:0] prod [9];
  logic signed [ACC_W-1:0] acc_sum;
  logic [ACC_W-1:0]  result_d;

  assign stall     = out_valid_q && !out_ready;
  assign in_ready  = (state_q == S_STREAM) && !stall;
  assign steps_end = total_q + KW'(cols_q) + KW_ONE;
  assign step      = ((state_q == S_STREAM) && in_valid && !stall) ||
                     ((state_q == S_DRAIN) && (k_q < steps_end) && !stall);
  assign pix_in    = (state_q == S_STREAM) ? in_data : '0;
  // Results exist once the window centre has entered the frame.
  assign produce   = k_q > KW'(cols_q);
  assign is_last   = k_q == (steps_end - KW_ONE);
  assign cfg_ok    = (cfg_cols >= COL_W'(2)) && (cfg_cols <= COL_W'(MAX_COLS)) &&
                     (cfg_rows >= ROW_W'(2));

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign busy      = state_q != S_IDLE;
  assign done      = done_q;
  assign err       = err_q;

  // Window after this step: shift left, new right column from line buffers and input.
  always_comb begin
    for (int t = 0; t < 9; t++) win_d[t] = '0;
    for (int r = 0; r < 3; r++) begin
      win_d[r*3 + 0] = win_q[r*3 + 1];
      win_d[r*3 + 1] = win_q[r*3 + 2];
    end
    win_d[2] = lb_top_mem[ptr_q];
    win_d[5] = lb_mid_mem[ptr_q];
    win_d[8] = pix_in;
  end

  // Border masks from the centre position; these also hide stale buffer data.
  always_comb begin
    row_ok[0] = cr_q != '0;
    row_ok[1] = 1'b1;
    row_ok[2] = cr_q != (rows_q - ROW_ONE);
    col_ok[0] = cc_q != '0;
    col_ok[1] = 1'b1;
    col_ok[2] = COL_W'(cc_q) != (cols_q - COL_ONE);
  end

  genvar gi;
  for (gi = 0; gi < 9; gi++) begin : g_tap
    logic signed [ACC_W-1:0] pix_ext, coef_ext;
    assign pix_ext  = $signed({{(ACC_W-DATA_W){1'b0}}, win_d[gi]});
    assign coef_ext = $signed({{(ACC_W-COEF_W){coef_q[gi][COEF_W-1]}}, coef_q[gi]});
    assign prod[gi] = (row_ok[gi/3] && col_ok[gi%3]) ? pix_ext * coef_ext : '0;
  end

  // Accumulate the nine masked products at full precision.
  always_comb begin
    acc_sum = '0;
    for (int t = 0; t < 9; t++) acc_sum = acc_sum + prod[t];
`ifdef CONV_RELU_EN
    result_d = acc_sum[ACC_W-1] ? '0 : acc_sum;
`else
    result_d = acc_sum;
`endif
  end

  // Kernel storage: identity on reset, writable only while idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int t = 0; t < 9; t++) coef_q[t] <= (t == 4) ? COEF_W'(1) : '0;
    end else if ((state_q == S_IDLE) && coef_we && (coef_addr <= 4'd8)) begin
      coef_q[coef_addr] <= coef_data;
    end
  end

  // Window and line buffers advance on each scan step; contents are never reset.
  always_ff @(posedge clk) begin
    if (step) begin
      for (int t = 0; t < 9; t++) win_q[t] <= win_d[t];
      lb_top_mem[ptr_q] <= lb_mid_mem[ptr_q];
      lb_mid_mem[ptr_q] <= pix_in;
    end
  end

  // Control FSM, scan/centre counters and the output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cols_q      <= '0;
      rows_q      <= '0;
      total_q     <= '0;
      k_q         <= '0;
      ptr_q       <= '0;
      cc_q        <= '0;
      cr_q        <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            if (cfg_ok) begin
              cols_q  <= cfg_cols;
              rows_q  <= cfg_rows;
              total_q <= KW'(cfg_rows) * KW'(cfg_cols);
              k_q     <= '0;
              ptr_q   <= '0;
              cc_q    <= '0;
              cr_q    <= '0;
              state_q <= S_STREAM;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        S_STREAM: if (step && (k_q == total_q - KW_ONE)) state_q <= S_DRAIN;
        S_DRAIN: begin
          if (out_valid_q && out_ready && out_last_q) begin
            state_q <= S_IDLE;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase

      if (step) begin
        k_q   <= k_q + KW_ONE;
        ptr_q <= (COL_W'(ptr_q) == cols_q - COL_ONE) ? '0 : ptr_q + PTR_ONE;
        if (produce) begin
          if (COL_W'(cc_q) == cols_q - COL_ONE) begin
            cc_q <= '0;
            cr_q <= cr_q + ROW_ONE;
          end else begin
            cc_q <= cc_q + PTR_ONE;
          end
        end
      end

      if (out_valid_q && out_ready) begin
        out_valid_q <= 1'b0;
        out_last_q  <= 1'b0;
      end
      if (step && produce) begin
        out_valid_q <= 1'b1;
        out_data_q  <= result_d;
        out_last_q  <= is_last;
      end
    end
  end
endmodule

// File: tb/tb_conv3x3_stream_engine.sv
// Scoreboard bench for conv3x3_stream_engine: a plain 2-D convolution model
// pushes expected results; a negedge monitor pops and compares them.
module tb_conv3x3_stream_engine;
  localparam int DATA_W = 8, COEF_W = 8, MAX_COLS = 16, ROW_W = 8;
  localparam int ACC_W = DATA_W + COEF_W + 5;
  localparam int COL_W = $clog2(MAX_COLS + 1);

  logic clk = 0, rst = 1, start = 0;
  logic [COL_W-1:0]  cfg_cols = '0;
  logic [ROW_W-1:0]  cfg_rows = '0;
  logic              coef_we = 0;
  logic [3:0]        coef_addr = '0;
  logic [COEF_W-1:0] coef_data = '0;
  logic              in_valid = 0, in_ready;
  logic [DATA_W-1:0] in_data = '0;
  logic              out_valid, out_ready = 1, out_last, busy, done, err;
  logic [ACC_W-1:0]  out_data;

  typedef struct { longint val; bit last; } exp_t;
  exp_t exp_q[$];
  int errors = 0, checks = 0, cyc = 0, done_cyc = -1, stall_req = 0;
  bit sb_en = 1, rand_ready = 0;
  int kern[9];
  int pix[4096];

  conv3x3_stream_engine #(.DATA_W(DATA_W), .COEF_W(COEF_W), .MAX_COLS(MAX_COLS),
                          .ROW_W(ROW_W), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_cols(cfg_cols), .cfg_rows(cfg_rows),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy), .done(done), .err(err));

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: direct 2-D convolution with zero padding outside the image.
  task automatic push_expected(input int cols, input int rows);
    for (int r = 0; r < rows; r++)
      for (int c = 0; c < cols; c++) begin
        exp_t e;
        longint s;
        s = 0;
        for (int i = -1; i <= 1; i++)
          for (int j = -1; j <= 1; j++)
            if (r + i >= 0 && r + i < rows && c + j >= 0 && c + j < cols)
              s += longint'(kern[(i+1)*3 + (j+1)]) * pix[(r+i)*cols + (c+j)];
`ifdef CONV_RELU_EN
        if (s < 0) s = 0;
`endif
        e.val  = s;
        e.last = (r == rows - 1) && (c == cols - 1);
        exp_q.push_back(e);
      end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // out_ready driver: forced stall window, random, or always ready.
  initial forever begin
    @(posedge clk);
    #2;
    if (stall_req > 0) begin
      out_ready = 0;
      stall_req--;
    end else if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    else out_ready = 1;
  end

  // Monitor: compare presented results with the scoreboard head each cycle.
  initial forever begin
    @(negedge clk);
    if (rst) continue;
    if (out_valid && !out_ready) check("stall_in_ready", in_ready, 0);
    if (out_valid && sb_en) begin
      if (exp_q.size() == 0) check("unexpected_output", 1, 0);
      else begin
        check("out_data", longint'($signed(out_data)), exp_q[0].val);
        check("out_last", out_last, exp_q[0].last);
        if (out_ready) begin
          if (exp_q[0].last) done_cyc = cyc + 1;
          void'(exp_q.pop_front());
        end
      end
    end
    if (cyc == done_cyc) begin
      check("done_pulse", done, 1);
      check("busy_after_done", busy, 0);
    end else if (done) check("spurious_done", done, 0);
  end

  task automatic write_coef(input int addr, input int val);
    @(posedge clk); #1;
    coef_we = 1; coef_addr = 4'(addr); coef_data = COEF_W'(val);
    @(posedge clk); #1;
    coef_we = 0;
    if (addr <= 8) kern[addr] = val;
  endtask

  task automatic feed_pixel(input int val, output bit ok);
    int waitc;
    in_valid = 1;
    in_data  = DATA_W'(val);
    waitc = 0;
    ok = 0;
    do begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk); #1;
      coef_we = 0;
      waitc++;
    end while (!ok && waitc < 300);
    if (!ok) check("in_accept_timeout", 0, 1);
  endtask

  task automatic start_frame(input int cols, input int rows);
    @(posedge clk); #1;
    cfg_cols = COL_W'(cols); cfg_rows = ROW_W'(rows); start = 1;
    @(posedge clk); #1;
    start = 0;
  endtask

  task automatic run_frame(input int cols, input int rows, input int gap_pct,
                           input int stall_at, input bit wr_during);
    bit ok;
    int waitc;
    push_expected(cols, rows);
    start_frame(cols, rows);
    check("busy_after_start", busy, 1);
    check("in_ready_after_start", in_ready, 1);
    for (int idx = 0; idx < rows * cols; idx++) begin
      while ($urandom_range(0, 99) < gap_pct) begin
        in_valid = 0;
        @(posedge clk); #1;
      end
      if (idx == stall_at) stall_req = 5;
      if (wr_during && idx == 2) begin
        coef_we = 1; coef_addr = 4'd4; coef_data = 8'd77;
      end
      feed_pixel(pix[idx], ok);
      if (!ok) break;
    end
    in_valid = 0;
    waitc = 0;
    do begin
      @(negedge clk);
      waitc++;
    end while (!done && waitc < 3000);
    if (!done) check("done_timeout", 0, 1);
  endtask

  task automatic bad_start(input int cols, input int rows);
    start_frame(cols, rows);
    check("err_pulse", err, 1);
    check("busy_on_reject", busy, 0);
    @(posedge clk); #1;
    check("err_one_cycle", err, 0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_in_ready"}, in_ready, 0);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_data"}, out_data, 0);
    check({tag, "_out_last"}, out_last, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_err"}, err, 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, got no end, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    for (int t = 0; t < 9; t++) kern[t] = (t == 4) ? 1 : 0;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    check_idle_outputs("reset");

    // Identity kernel straight after reset: output equals input.
    for (int t = 0; t < 9; t++) pix[t] = t + 1;
    run_frame(3, 3, 0, -1, 0);

    // All-ones kernel on a flat image; a STREAM-time write must be ignored.
    for (int t = 0; t < 9; t++) write_coef(t, 1);
    for (int t = 0; t < 9; t++) pix[t] = 10;
    run_frame(3, 3, 0, -1, 1);

    // 4x3 frame with a forced five-cycle output stall mid-frame.
    for (int t = 0; t < 12; t++) pix[t] = $urandom_range(0, 255);
    run_frame(4, 3, 0, 7, 0);

    // Negative centre tap.
    for (int t = 0; t < 9; t++) write_coef(t, (t == 4) ? -1 : 0);
    for (int t = 0; t < 9; t++) pix[t] = $urandom_range(0, 255);
    pix[4] = 5;
    run_frame(3, 3, 0, -1, 0);

    // Rejected configurations and the smallest legal frame.
    bad_start(1, 3);
    bad_start(MAX_COLS + 1, 3);
    bad_start(4, 1);
    bad_start(0, 0);
    write_coef(9, 55);
    write_coef(15, -7);
    for (int t = 0; t < 4; t++) pix[t] = $urandom_range(0, 255);
    run_frame(2, 2, 0, -1, 0);

    // Reset in the middle of a 4x4 frame, then a clean identity frame.
    sb_en = 0;
    for (int t = 0; t < 9; t++) write_coef(t, int'($urandom_range(0, 255)) - 128);
    start_frame(4, 4);
    for (int t = 0; t < 5; t++) feed_pixel($urandom_range(1, 255), ok);
    in_valid = 0;
    rst = 1;
    @(posedge clk); @(posedge clk); #1;
    rst = 0;
    check_idle_outputs("midreset");
    exp_q.delete();
    done_cyc = -1;
    sb_en = 1;
    for (int t = 0; t < 9; t++) kern[t] = (t == 4) ? 1 : 0;
    for (int t = 0; t < 16; t++) pix[t] = $urandom_range(1, 255);
    run_frame(4, 4, 0, -1, 0);

    // Random kernels, sizes, input gaps and output backpressure.
    rand_ready = 1;
    for (int f = 0; f < 6; f++) begin
      int cols, rows;
      cols = (f == 0) ? MAX_COLS : $urandom_range(2, MAX_COLS);
      rows = $urandom_range(2, 5);
      for (int t = 0; t < 9; t++) write_coef(t, int'($urandom_range(0, 255)) - 128);
      for (int t = 0; t < cols * rows; t++) pix[t] = $urandom_range(0, 255);
      run_frame(cols, rows, 25, -1, 0);
    end
    rand_ready = 0;
    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
